// File: rtl/mem_pkg.sv
// mem_pkg: shared constants and types for the mem_responder slice.
//   WORD_W         data word width (16)
//   DEF_LATENCY    default request-to-ready latency in cycles
//   DEF_ADDR_BITS  default log2 of storage depth in words
//   CNT_W          width of the latency down-counter (covers LATENCY up to 15)
//   ST_*           FSM state encoding
//   req_t          latched request (op, address, store data)
package mem_pkg;

  localparam int WORD_W        = 16;
  localparam int DEF_LATENCY   = 2;
  localparam int DEF_ADDR_BITS = 8;
  localparam int CNT_W         = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic                 is_wr;
    logic [WORD_W-1:0]    addr;
    logic [WORD_W-1:0]    wdata;
  } req_t;

endpackage

// File: rtl/mem_array.sv
// mem_array: 2^ADDR_BITS x WORD_W storage, synchronous write and synchronous
// read. Pure datapath; all enables come from the controller.
//   clk    clock, rising edge
//   we     write enable: mem[addr] <= wdata
//   re     read enable:  rdata <= mem[addr]
//   addr   word address
//   wdata  store data
//   rdata  registered read data, holds between reads
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [WORD_W-1:0]    wdata,
  output logic [WORD_W-1:0]    rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency memory responder for a pipeline load/store port.
// A request held on mem_read or mem_write is accepted in IDLE, waits out the
// programmed latency, then completes with a one-cycle mem_ready pulse.
//   clk         clock, rising edge
//   reset_n     asynchronous active-low reset
//   mem_read    read request, held until mem_ready
//   mem_write   write request, held until mem_ready
//   address     word address (upper bits beyond ADDR_BITS ignored)
//   write_data  store data
//   read_data   registered load data, 0 until the first read after reset
//   mem_ready   one-cycle completion pulse
//   mem_busy    high while a request is in flight
//   err         one-cycle pulse when read and write are requested together
//
// state | meaning
// IDLE  | sampling mem_read/mem_write for a new request
// WAIT  | request latched, counting down remaining latency
// RESP  | access performed on entry; mem_ready high this cycle
module mem_responder
  import mem_pkg::*;
#(
  parameter int LATENCY   = DEF_LATENCY,
  parameter int ADDR_BITS = DEF_ADDR_BITS
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] address,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  output logic        mem_ready,
  output logic        mem_busy,
  output logic        err
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  req_t                 req_q, req_d;
  logic                 ready_q, ready_d;
  logic                 err_q, err_d;
  logic                 rd_valid_q, rd_valid_d;

  logic                 arr_we;
  logic                 arr_re;
  logic [WORD_W-1:0]    arr_rdata;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    rd_valid_d = rd_valid_q;
    arr_we     = 1'b0;
    arr_re     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mem_read && mem_write) begin
          err_d = 1'b1;
        end else if (mem_read || mem_write) begin
          req_d.is_wr = mem_write;
          req_d.addr  = address;
          req_d.wdata = write_data;
          cnt_d       = CNT_INIT;
          state_d     = (CNT_INIT == '0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Leave on the edge where the count reaches zero so that mem_ready
        // lands exactly LATENCY cycles after the request cycle.
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // The array access happens on the edge entering RESP. The array is fed
    // from req_d so a LATENCY=1 request coming straight from IDLE works too.
    // Enables are gated by reset_n so nothing commits while reset is held.
    if (state_d == ST_RESP && state_q != ST_RESP) begin
      ready_d = 1'b1;
      arr_we  = reset_n & req_d.is_wr;
      arr_re  = reset_n & ~req_d.is_wr;
      if (!req_d.is_wr) begin
        rd_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      req_q      <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  mem_array #(
    .ADDR_BITS (ADDR_BITS)
  ) u_mem_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (req_d.addr[ADDR_BITS-1:0]),
    .wdata (req_d.wdata),
    .rdata (arr_rdata)
  );

  // The array read register is not reset; rd_valid masks it to zero until
  // the first read after reset completes.
  assign read_data = rd_valid_q ? arr_rdata : '0;
  assign mem_ready = ready_q;
  assign mem_busy  = (state_q != ST_IDLE);
  assign err       = err_q;

  generate
    if (ADDR_BITS < WORD_W) begin : g_unused_addr
      logic unused_addr_hi;
      assign unused_addr_hi = ^req_q.addr[WORD_W-1:ADDR_BITS];
    end
  endgenerate

endmodule
